// File: rtl/spi_pkg.sv
// spi_pkg: word/counter widths and FSM state encoding shared by the SPI slave blocks.
package spi_pkg;

  localparam int SPI_WORD_W = 32;
  localparam int SPI_CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: 2-flop synchronizer plus a history flop for single-cycle rise/fall detection.
// Adds 2 CLK of latency; the edge pulses line up with the synchronized level q.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
    end
  end

  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI mode-0 slave, 32-bit MSB-first words, back-to-back words while cs stays low.
// Macro SPI_SLAVE_LOOPBACK_EN: the tx shift register loads the current rx_data instead of tx_data.
module spi_slave_if
  import spi_pkg::*;
(
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  spi_cs,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic [SPI_WORD_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [SPI_WORD_W-1:0] tx_data,
  output logic                  tx_load,
  output logic                  frame_err
);

  logic cs_q, cs_rise, cs_fall;
  logic sck_q, sck_rise, sck_fall;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(CLK), .rst(rst_n), .d(spi_cs), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(CLK), .rst(rst_n), .d(spi_sck), .q(sck_q), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(CLK), .rst(rst_n), .d(spi_mosi), .q(mosi_q),
    .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_e            state, state_nxt;
  logic [SPI_CNT_W-1:0]  bit_cnt;
  logic [SPI_WORD_W-1:0] rx_shift;
  logic [SPI_WORD_W-1:0] tx_shift;
  logic [SPI_WORD_W-1:0] capture_val;
  logic [1:0]            settle;
  logic                  armed;
  logic                  capture, shift_in, shift_out, word_done, err;

`ifdef SPI_SLAVE_LOOPBACK_EN
  logic unused_tx;
  assign unused_tx   = ^tx_data;
  assign capture_val = rx_data;
`else
  assign capture_val = tx_data;
`endif

  always_ff @(posedge CLK) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    shift_in  = 1'b0;
    shift_out = 1'b0;
    word_done = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          state_nxt = SHIFT;
          capture   = 1'b1;
        end
      end
      SHIFT: begin
        shift_in  = sck_rise;
        // With the counter at 0 the pending fall is the previous word's last one
        shift_out = sck_fall && (bit_cnt != '0);
        if (sck_rise && (&bit_cnt)) begin
          state_nxt = DONE;
        end else if (cs_rise) begin
          state_nxt = IDLE;
          err       = (bit_cnt != '0);
        end
      end
      DONE: begin
        word_done = 1'b1;
        if (cs_q) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = SHIFT;
          capture   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst_n) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      frame_err <= 1'b0;
      settle    <= '0;
      armed     <= 1'b0;
    end else begin
      rx_valid  <= word_done;
      tx_load   <= capture;
      frame_err <= err;
      // Synchronizer chains hold reset values for two cycles; only trust cs after that
      if (settle != 2'b11) settle <= settle + 2'b01;
      armed <= armed | ((settle == 2'b11) & cs_q);
      if (capture) begin
        tx_shift <= capture_val;
        bit_cnt  <= '0;
      end else if (shift_out) begin
        tx_shift <= {tx_shift[SPI_WORD_W-2:0], 1'b0};
      end
      if (shift_in) begin
        rx_shift <= {rx_shift[SPI_WORD_W-2:0], mosi_q};
        bit_cnt  <= bit_cnt + SPI_CNT_W'(1);
      end
      if (word_done) rx_data <= rx_shift;
    end
  end

  assign spi_miso = (state != IDLE) & tx_shift[SPI_WORD_W-1];

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: mode-0 master model drives frames, a monitor scoreboards rx words.
module tb_spi_slave_if;

  localparam int HALF = 60;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b1;
  logic        spi_cs = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic [31:0] tx_data = 32'h0;
  logic        tx_load;
  logic        frame_err;

  int          n_assert = 0;
  int          n_fail = 0;
  int          n_txload = 0;
  int          n_ferr = 0;
  logic [31:0] exp_rx[$];
  logic [31:0] model_rx = 32'h0;

  spi_slave_if dut (
    .CLK(CLK), .rst_n(rst_n), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_load(tx_load), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endfunction

  // Word the slave is expected to shift out for a capture of tx value txv
  function automatic logic [31:0] exp_tx(input logic [31:0] txv);
`ifdef SPI_SLAVE_LOOPBACK_EN
    return model_rx;
`else
    return txv;
`endif
  endfunction

  always @(negedge CLK) begin
    if (tx_load) n_txload++;
    if (frame_err) n_ferr++;
    if (rx_valid) begin
      if (exp_rx.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL rx_unexpected: actual rx_data=%h required no rx_valid", rx_data);
      end else begin
        check("rx_data", rx_data, exp_rx.pop_front());
      end
    end
  end

  task automatic send_bits(input logic [31:0] w, input int n, input bit cs_with_last,
                           output logic [31:0] m);
    m = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = w[31-i];
      #(HALF);
      spi_sck = 1'b1;
      if (cs_with_last && (i == n - 1)) spi_cs = 1'b1;
      m = {m[30:0], spi_miso};
      #(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic settle_clk(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic do_frame(input logic [31:0] w, input logic [31:0] txv, input string nm);
    logic [31:0] m, e;
    int t0, f0;
    t0 = n_txload;
    f0 = n_ferr;
    tx_data = txv;
    e = exp_tx(txv);
    exp_rx.push_back(w);
    spi_cs = 1'b0;
    #200;
    send_bits(w, 32, 1'b0, m);
    #(HALF);
    spi_cs = 1'b1;
    settle_clk(12);
    check({nm, "_miso"}, m, e);
    check({nm, "_tx_load_cnt"}, n_txload - t0, 2);
    check({nm, "_frame_err_cnt"}, n_ferr - f0, 0);
    model_rx = w;
  endtask

  initial begin
    #200000;
    n_assert++;
    n_fail++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] m1, m2, e1, e2;
    int t0, f0;

    settle_clk(5);
    @(negedge CLK);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", 32'(rx_valid), 0);
    check("reset_tx_load", 32'(tx_load), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    check("reset_miso", 32'(spi_miso), 0);
    settle_clk(1);
    rst_n = 1'b0;
    settle_clk(10);

    do_frame(32'hA5A5_1234, 32'hDEAD_BEEF, "frame1");

    // Burst: tx_data changes after the initial capture so each word carries its own payload
    t0 = n_txload;
    f0 = n_ferr;
    tx_data = 32'h1234_5678;
    e1 = exp_tx(32'h1234_5678);
    e2 = exp_tx(32'h9ABC_DEF0);
    exp_rx.push_back(32'h0000_0001);
    exp_rx.push_back(32'hFFFF_FFFE);
    spi_cs = 1'b0;
    #200;
    tx_data = 32'h9ABC_DEF0;
    send_bits(32'h0000_0001, 32, 1'b0, m1);
    send_bits(32'hFFFF_FFFE, 32, 1'b0, m2);
    #(HALF);
    spi_cs = 1'b1;
    settle_clk(12);
    check("burst_miso_w1", m1, e1);
    check("burst_miso_w2", m2, e2);
    check("burst_tx_load_cnt", n_txload - t0, 3);
    check("burst_frame_err_cnt", n_ferr - f0, 0);
    model_rx = 32'hFFFF_FFFE;

    // Short frame of 17 bits
    t0 = n_txload;
    f0 = n_ferr;
    spi_cs = 1'b0;
    #200;
    send_bits(32'h8000_0000, 17, 1'b0, m1);
    #(HALF);
    spi_cs = 1'b1;
    settle_clk(12);
    check("short_frame_err_cnt", n_ferr - f0, 1);
    check("short_tx_load_cnt", n_txload - t0, 1);
    check("short_rx_data_kept", rx_data, model_rx);

    // Reset at bit 10, cs held low across release
    spi_cs = 1'b0;
    #200;
    send_bits(32'hFFFF_FFFF, 10, 1'b0, m1);
    rst_n = 1'b1;
    settle_clk(3);
    @(negedge CLK);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_rx_valid", 32'(rx_valid), 0);
    check("midrst_tx_load", 32'(tx_load), 0);
    check("midrst_frame_err", 32'(frame_err), 0);
    check("midrst_miso", 32'(spi_miso), 0);
    settle_clk(1);
    rst_n = 1'b0;
    model_rx = 32'h0;
    t0 = n_txload;
    f0 = n_ferr;
    send_bits(32'hFFFF_FFFF, 5, 1'b0, m1);
    check("midrst_stale_miso", m1, 0);
    #(HALF);
    spi_cs = 1'b1;
    settle_clk(12);
    check("midrst_stale_frame_err_cnt", n_ferr - f0, 0);
    check("midrst_stale_tx_load_cnt", n_txload - t0, 0);
    do_frame(32'h1357_9BDF, 32'h0F0F_0F0F, "after_rst");

    do_frame(32'h1111_2222, 32'h5555_AAAA, "lb_first");
    do_frame(32'h3333_4444, 32'h6666_7777, "lb_second");

    // cs rises with the 32nd sck rise
    t0 = n_txload;
    f0 = n_ferr;
    tx_data = 32'h0BAD_CAFE;
    e1 = exp_tx(32'h0BAD_CAFE);
    exp_rx.push_back(32'hCAFE_F00D);
    spi_cs = 1'b0;
    #200;
    send_bits(32'hCAFE_F00D, 32, 1'b1, m1);
    settle_clk(12);
    check("edge_miso", m1, e1);
    check("edge_frame_err_cnt", n_ferr - f0, 0);
    check("edge_tx_load_cnt", n_txload - t0, 1);
    check("edge_rx_data", rx_data, 32'hCAFE_F00D);

    settle_clk(10);
    check("rx_queue_drained", exp_rx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
SPI_SLAVE_IF -- requirements
Module: spi_slave_if

Interface
- REQ-001 SHALL have port CLK, input, 1 bit: single block clock; all logic on rising edge.
- REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-high (1 = reset).
- REQ-003 SHALL have port spi_cs, input, 1 bit: chip select from master, active-low, asynchronous to CLK.
- REQ-004 SHALL have port spi_sck, input, 1 bit: SPI clock, mode 0, idle low, asynchronous to CLK.
- REQ-005 SHALL have port spi_mosi, input, 1 bit: serial data from master, MSB first.
- REQ-006 SHALL have port spi_miso, output, 1 bit: serial data to master, MSB first.
- REQ-007 SHALL have port rx_data, output, 32 bits: last complete received word.
- REQ-008 SHALL have port rx_valid, output, 1 bit: one-CLK pulse when rx_data updates.
- REQ-009 SHALL have port tx_data, input, 32 bits: word to transmit in the next frame.
- REQ-010 SHALL have port tx_load, output, 1 bit: one-CLK pulse when tx_data is captured.
- REQ-011 SHALL have port frame_err, output, 1 bit: one-CLK pulse on a short frame.

Function
- REQ-012 SHALL pass spi_cs, spi_sck and spi_mosi through 2-flop synchronizers, then detect edges on the synchronized cs and sck.
- REQ-013 SHALL support SCK frequency up to CLK/8; behaviour above CLK/8 is undefined.
- REQ-014 SHALL implement the FSM states IDLE, SHIFT and DONE.
- REQ-015 In IDLE, a synchronized cs falling edge SHALL move the FSM to SHIFT, capture tx_data into the tx shift register, pulse tx_load, clear the bit counter and drive spi_miso = tx bit 31.
- REQ-016 In SHIFT, each synchronized sck rising edge SHALL shift synchronized mosi into the rx shift register LSB and increment the 5-bit bit counter.
- REQ-017 In SHIFT, each synchronized sck falling edge SHALL shift the tx register left and drive the next MSB on spi_miso.
- REQ-018 When the 32nd rising edge occurs (counter 31 -> 0 wrap), the FSM SHALL go to DONE; the next cycle SHALL load rx_data, pulse rx_valid and return to SHIFT.
- REQ-019 On that return to SHIFT, tx_data SHALL be recaptured with a tx_load pulse, so back-to-back words without cs release are supported.
- REQ-020 A cs rising edge while the counter is 0 SHALL return the FSM to IDLE silently.
- REQ-021 A cs rising edge while the counter is 1..31 SHALL pulse frame_err, discard the partial word, leave rx_data unchanged and return the FSM to IDLE.
- REQ-022 If the cs rising edge and the 32nd sck rising edge are detected in the same cycle, the word SHALL complete (rx_valid) and frame_err SHALL stay low.
- REQ-023 sck edges while in IDLE SHALL be ignored.
- REQ-024 spi_miso SHALL be 0 whenever the FSM is in IDLE.

Reset
- REQ-025 While rst_n = 1 at a CLK edge: FSM = IDLE, counter = 0, shift registers = 0, rx_data = 0, rx_valid = 0, tx_load = 0, frame_err = 0, spi_miso = 0, synchronizers = idle (cs = 1, sck = 0).
- REQ-026 Reset asserted mid-frame SHALL abort the frame with no rx_valid and no frame_err; after release, a new frame SHALL start only on a fresh cs falling edge.

Configuration
- REQ-027 With macro SPI_SLAVE_LOOPBACK_EN defined, the tx shift register SHALL load the current rx_data instead of tx_data at each capture point; tx_load SHALL still pulse.
- REQ-028 Without SPI_SLAVE_LOOPBACK_EN, tx_data SHALL be used as specified; the loopback path SHALL not be synthesized.

Structure
- REQ-029 Shared package spi_pkg SHALL hold SPI_WORD_W = 32, SPI_CNT_W = 5 and the FSM state encoding.
- REQ-030 Sub-module spi_sync SHALL implement the 2-flop synchronizer and edge detector, instanced per input; all remaining logic SHALL stay in spi_slave_if.

Verification
- REQ-031 Frame: master sends 0xA5A5_1234 with tx_data = 0xDEAD_BEEF -> rx_data = 0xA5A5_1234 with one rx_valid pulse; master samples 0xDEAD_BEEF on MISO.
- REQ-032 Burst: two words 0x0000_0001 and 0xFFFF_FFFE sent without releasing cs -> two rx_valid pulses with the values in order; two tx_load pulses after the initial one.
- REQ-033 Short frame: cs released after 17 bits -> frame_err pulses once, no rx_valid, rx_data keeps its prior value.
- REQ-034 Reset mid-frame: rst_n = 1 at bit 10 -> all outputs 0; the next full frame 0x1357_9BDF is received correctly.
- REQ-035 Loopback build: frame 0x1111_2222 followed by any second frame -> MISO returns 0x1111_2222 during the second frame.
- REQ-036 Edge case: cs rises in the same synchronized cycle as the 32nd sck rise -> rx_valid = 1, frame_err = 0.
